// File: rtl/lsu_bus_pkg.sv
// Shared definitions for the load/store bus initiator.
//   - request size codes (byte/half/word; code 3 is illegal)
//   - FSM state encoding
//   - be_mask:    byte-lane enable mask for a size and address offset
//   - misaligned: true when a request cannot be issued as one bus word access
package lsu_bus_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    RD_WAIT = 3'd3,
    RESP    = 3'd4
  } state_t;

  function automatic logic [3:0] be_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_bus_master_lsu_lane_align.sv
// Combinational byte-lane steering for the load/store bus initiator.
// Ports:
//   wr_size, wdata     -> wdata_rep : store data replicated onto every lane
//   rd_size, rd_off,
//   rd_signed, rdata   -> rdata_ext : load data shifted down, masked, extended
module lsu_lane_align
  import lsu_bus_pkg::*;
(
  input  logic [1:0]  wr_size,
  input  logic [31:0] wdata,
  input  logic [1:0]  rd_size,
  input  logic [1:0]  rd_off,
  input  logic        rd_signed,
  input  logic [31:0] rdata,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] rd_shift;

  always_comb begin
    case (wr_size)
      SZ_BYTE: wdata_rep = {4{wdata[7:0]}};
      SZ_HALF: wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  end

  assign rd_shift = rdata >> {rd_off, 3'b000};

  always_comb begin
    case (rd_size)
      SZ_BYTE: rdata_ext = {{24{rd_signed & rd_shift[7]}}, rd_shift[7:0]};
      SZ_HALF: rdata_ext = {{16{rd_signed & rd_shift[15]}}, rd_shift[15:0]};
      default: rdata_ext = rd_shift;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store bus initiator: turns one CPU byte/half/word request at a time
// into a word-aligned, byte-enabled Avalon-MM style read or write.
// Ports:
//   clock, resetn                 clock, async active-low reset
//   req_*                         CPU request (valid/ready handshake)
//   rsp_valid/rsp_rdata/rsp_err   one-cycle completion with load data or error
//   avm_*                         bus command outputs and slave responses
module lsu_bus_master
  import lsu_bus_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  output logic              avm_write,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  // state   | meaning
  // IDLE    | ready for a new request
  // WR      | write command on the bus, held while waitrequest
  // RD      | read command on the bus, held while waitrequest
  // RD_WAIT | read accepted, waiting for readdatavalid
  // RESP    | rsp_valid pulse, then back to IDLE

  state_t      state, state_d;
  logic [1:0]  off_q, size_q;
  logic        signed_q;
  logic        accept, bad, capture;
  logic [31:0] wdata_rep, rdata_ext;

  assign req_ready = resetn && (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign bad       = misaligned(req_size, req_addr[1:0]);
  assign capture   = avm_readdatavalid &&
                     ((state == RD && !avm_waitrequest) || state == RD_WAIT);

  lsu_lane_align u_align (
    .wr_size   (req_size),
    .wdata     (req_wdata),
    .rd_size   (size_q),
    .rd_off    (off_q),
    .rd_signed (signed_q),
    .rdata     (avm_readdata),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = bad ? RESP : (req_write ? WR : RD);
      WR:      if (!avm_waitrequest) state_d = RESP;
      RD:      if (!avm_waitrequest) state_d = avm_readdatavalid ? RESP : RD_WAIT;
      RD_WAIT: if (avm_readdatavalid) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Only the IDLE accept loads bus fields; they then hold until the next
  // accept. Response data/err update only on the way into RESP.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      off_q          <= '0;
      size_q         <= '0;
      signed_q       <= 1'b0;
      avm_address    <= '0;
      avm_byteenable <= '0;
      avm_writedata  <= '0;
      avm_write      <= 1'b0;
      avm_read       <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
    end else begin
      rsp_valid <= (state_d == RESP);
      case (state)
        IDLE: if (accept) begin
          off_q    <= req_addr[1:0];
          size_q   <= req_size;
          signed_q <= req_signed;
          if (bad) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            avm_address    <= {req_addr[ADDR_W-1:2], 2'b00};
            avm_byteenable <= be_mask(req_size, req_addr[1:0]);
            avm_writedata  <= wdata_rep;
            avm_write      <= req_write;
            avm_read       <= !req_write;
          end
        end
        WR: if (!avm_waitrequest) begin
          avm_write <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        RD: if (!avm_waitrequest) avm_read <= 1'b0;
        default: ;
      endcase
      if (capture) begin
        rsp_rdata <= rdata_ext;
        rsp_err   <= 1'b0;
      end
    end
  end

endmodule
